apa102_sync_rx: RTL and testbench
=================================

Name: apa102_sync_rx

Overview:
Clock-domain APA102 receiver that sits directly upstream of the WS2812 `led` driver. It oversamples the APA102 SCK/SDA pins on the system clock and parses start and LED frames. Colour data is collected in a shadow buffer and committed atomically to a GRB-ordered frame bus once a full strip of LED_CNT pixels has arrived. This removes the SCK-domain capture path, so the WS2812 driver never sees a partially updated frame.

Parameters:
LED_CNT, 7, number of pixels per frame; sets frame_data width to LED_CNT*24
SYNC_STAGES, 2, synchroniser flops on sck and sda; legal values are 2 or more
IDLE_TIMEOUT, 4096, clk cycles with no sck rising edge before a mid-frame abort

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
sck  input  1  APA102 serial clock (pin, asynchronous)
sda  input  1  APA102 serial data (pin, asynchronous), MSB first
frame_data  output  LED_CNT*24  committed pixels, pixel 0 in the MSBs, each pixel {G,R,B}
frame_valid  output  1  one-cycle pulse in the cycle frame_data updates
sync_err  output  1  one-cycle pulse when an LED frame header is not 3'b111

Behaviour:
- Reset (async assert, sync to clk on deassert):
  - state=HUNT, all counters 0, shadow buffer 0, synchroniser flops 0
  - frame_data=0, frame_valid=0, sync_err=0
- Synchronisers: sck and sda each pass through SYNC_STAGES flops. One extra flop on the synchronised sck is used for rising-edge detect.
- Sampling: a bit is taken from synchronised sda in the cycle a synchronised sck rising edge is detected. Falling edges are ignored.
- Supported rate: sck high time and sck low time are each at least 3 clk cycles.
- Bit counter: bit_cnt is 5 bits and wraps 31->0. pix_idx counts 0..LED_CNT-1. zero_cnt counts 0..32 and saturates.
- HUNT state:
  - Each sampled 0 increments zero_cnt; each sampled 1 clears it.
  - When zero_cnt reaches 32: go to PIXEL with bit_cnt=0 and pix_idx=0.
- PIXEL state:
  - Shift each sampled bit into a 32-bit word. When bit_cnt=31, evaluate the completed word w.
  - If w[31:29]==3'b111: store {w[15:8],w[7:0],w[23:16]} in shadow slot pix_idx, then increment pix_idx. w[28:24] (global brightness) is discarded.
  - Else if w==0: treat it as a repeated start frame; set pix_idx=0 and stay in PIXEL. No error.
  - Else: pulse sync_err, go to HUNT, clear zero_cnt. The shadow buffer is not committed.
- Commit: when the slot for pix_idx==LED_CNT-1 is stored, the next clk cycle copies the whole shadow buffer to frame_data and pulses frame_valid for 1 cycle. State then returns to HUNT with zero_cnt=0.
- Shadow slot mapping: pixel i occupies frame_data[(LED_CNT-1-i)*24 +: 24].
- End frames: trailing 1s after the last pixel, or extra pixels beyond LED_CNT, are absorbed in HUNT and have no effect.
- Latency: sck rising at pin -> bit registered after SYNC_STAGES+1 clk cycles. Final bit registered -> frame_valid and frame_data visible 1 clk later.
- Idle timeout:
  - An idle counter clears on every sampled sck edge and otherwise increments.
  - When it reaches IDLE_TIMEOUT while in PIXEL: go to HUNT, zero_cnt=0, no commit, no sync_err.
  - In HUNT the idle counter saturates with no effect.
- Simultaneous events: the commit and a new sck edge in the same cycle are both honoured. The edge's bit is processed in HUNT with the cleared zero_cnt.
- Reset mid-frame: the shadow buffer and frame_data both return to 0 immediately.
- frame_data holds its value indefinitely between commits.

Test Plan:
- Reset check: assert reset mid-transfer with frame_data=nonzero -> frame_data=0, frame_valid=0, state=HUNT, all while clk is stopped.
- Full frame: 32 zeros, then 7 frames 0xE1_0000FF through 0xE7_...; pixel 0 has B=0x00,G=0x00,R=0xFF. Then 32 ones, with sck period 8 clk -> exactly one frame_valid pulse, SYNC_STAGES+2 clk after the last sck rise. frame_data[167:144]=0x00FF00 (GRB).
- Bad header: start frame, then pixel 0 = 0x6A_112233 -> sync_err pulse after bit 31, no frame_valid, frame_data unchanged. A following valid frame commits normally.
- Repeated start: 64 zeros, then 7 valid pixels -> single commit, pixels land in slots 0..6, no sync_err.
- Idle abort: start frame plus 3 pixels, then sck held for IDLE_TIMEOUT+10 clk, then a fresh full frame -> only the fresh frame commits. The earlier 3 pixels never appear.
- Extra pixels: start frame plus 9 valid pixels -> commit after pixel 6, pixels 7–8 ignored, no sync_err.

Source files
------------

// File: rtl/apa102_sync_rx.sv
// APA102 receiver oversampled on clk: hunts for a 32-zero start frame, collects LED
// frames into a shadow buffer and commits a full strip atomically as GRB pixels.
module apa102_sync_rx #(
    parameter int LED_CNT      = 7,
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  sda,
    output logic [LED_CNT*24-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  sync_err
);

    localparam int FW     = LED_CNT * 24;
    localparam int PIX_W  = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [0:0] ST_HUNT  = 1'b0;
    localparam logic [0:0] ST_PIXEL = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   sck_prev_q;

    logic [0:0]        state_q,    state_d;
    logic [4:0]        bit_cnt_q,  bit_cnt_d;
    logic [PIX_W-1:0]  pix_idx_q,  pix_idx_d;
    logic [5:0]        zero_cnt_q, zero_cnt_d;
    logic [IDLE_W-1:0] idle_q,     idle_d;
    logic [30:0]       word_q,     word_d;
    logic [FW-1:0]     shadow_q,   shadow_d;
    logic              commit_q,   commit_d;
    logic [FW-1:0]     frame_q,    frame_d;
    logic              fv_q,       fv_d;
    logic              err_q,      err_d;

    logic        sck_rise;
    logic        sda_bit;
    logic [31:0] word_full;

    // APA102 colour bytes are {B,G,R}; the frame bus wants {G,R,B}
    function automatic logic [23:0] to_grb(input logic [23:0] bgr);
        return {bgr[15:8], bgr[7:0], bgr[23:16]};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q <= '0;
            sda_sync_q <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_rise  = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sda_bit   = sda_sync_q[SYNC_STAGES-1];
    assign word_full = {word_q, sda_bit};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        pix_idx_d  = pix_idx_q;
        zero_cnt_d = zero_cnt_q;
        idle_d     = idle_q;
        word_d     = word_q;
        shadow_d   = shadow_q;
        commit_d   = 1'b0;
        frame_d    = frame_q;
        fv_d       = 1'b0;
        err_d      = 1'b0;

        if (commit_q) begin
            frame_d = shadow_q;
            fv_d    = 1'b1;
        end

        if (sck_rise) begin
            idle_d = '0;
        end else if (idle_q != IDLE_W'(IDLE_TIMEOUT)) begin
            idle_d = idle_q + 1'b1;
        end

        if (state_q == ST_HUNT) begin
            if (sck_rise) begin
                if (sda_bit) begin
                    zero_cnt_d = '0;
                end else if (zero_cnt_q != 6'd32) begin
                    zero_cnt_d = zero_cnt_q + 6'd1;
                end
                if (!sda_bit && zero_cnt_q == 6'd31) begin
                    state_d   = ST_PIXEL;
                    bit_cnt_d = '0;
                    pix_idx_d = '0;
                end
            end
        end else begin
            if (sck_rise) begin
                word_d    = word_full[30:0];
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    if (word_full[31:29] == 3'b111) begin
                        shadow_d[(LED_CNT-1-int'(pix_idx_q))*24 +: 24] = to_grb(word_full[23:0]);
                        if (pix_idx_q == PIX_W'(LED_CNT - 1)) begin
                            commit_d   = 1'b1;
                            state_d    = ST_HUNT;
                            zero_cnt_d = '0;
                        end else begin
                            pix_idx_d = pix_idx_q + 1'b1;
                        end
                    end else if (word_full == 32'h0) begin
                        // another start frame: restart the strip without complaint
                        pix_idx_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        state_d    = ST_HUNT;
                        zero_cnt_d = '0;
                    end
                end
            end else if (idle_q == IDLE_W'(IDLE_TIMEOUT)) begin
                state_d    = ST_HUNT;
                zero_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_HUNT;
            bit_cnt_q  <= '0;
            pix_idx_q  <= '0;
            zero_cnt_q <= '0;
            idle_q     <= '0;
            word_q     <= '0;
            shadow_q   <= '0;
            commit_q   <= 1'b0;
            frame_q    <= '0;
            fv_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            pix_idx_q  <= pix_idx_d;
            zero_cnt_q <= zero_cnt_d;
            idle_q     <= idle_d;
            word_q     <= word_d;
            shadow_q   <= shadow_d;
            commit_q   <= commit_d;
            frame_q    <= frame_d;
            fv_q       <= fv_d;
            err_q      <= err_d;
        end
    end

    assign frame_data  = frame_q;
    assign frame_valid = fv_q;
    assign sync_err    = err_q;

endmodule

// File: tb/tb_apa102_sync_rx.sv
// Bench for apa102_sync_rx: single-word vector table, hand-written multi-cycle
// sequences and randomized streams compared with a word-level protocol model.
module tb_apa102_sync_rx;
    localparam int LED_CNT      = 7;
    localparam int SYNC_STAGES  = 2;
    localparam int IDLE_TIMEOUT = 4096;
    localparam int FW           = LED_CNT * 24;

    // kind: 0/1 = data bit sampled at a sck rise, 2 = idle gap longer than the timeout
    typedef struct { int kind; int cyc; } ev_t;
    typedef struct { logic [31:0] w; int exp_fv; int exp_se; logic [23:0] exp_slot0; } vec_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          sck   = 1'b0;
    logic          sda   = 1'b0;
    bit            clk_en = 1'b1;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          sync_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lo_t  = 4;
    int hi_t  = 4;
    bit rnd_t = 1'b0;

    ev_t           stream[$];
    int            fv_cyc[$];
    logic [FW-1:0] fv_dat[$];
    int            se_cyc[$];
    int            exp_fv_cyc[$];
    logic [FW-1:0] exp_fv_dat[$];
    int            exp_se_cyc[$];

    apa102_sync_rx #(
        .LED_CNT     (LED_CNT),
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .sda        (sda),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .sync_err   (sync_err)
    );

    initial forever #5 clk = clk_en ? ~clk : 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (frame_valid === 1'b1) begin
            fv_cyc.push_back(cyc);
            fv_dat.push_back(frame_data);
        end
        if (sync_err === 1'b1) se_cyc.push_back(cyc);
    end

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_q();
        stream.delete();
        fv_cyc.delete();
        fv_dat.delete();
        se_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        sck   = 1'b0;
        sda   = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_q();
        repeat (2) @(negedge clk);
    endtask

    // Called at a negedge; sda changes together with the falling sck.
    task automatic send_bit(input bit b);
        int lo = rnd_t ? int'($urandom_range(4, 3)) : lo_t;
        int hi = rnd_t ? int'($urandom_range(4, 3)) : hi_t;
        sck = 1'b0;
        sda = b;
        repeat (lo) @(negedge clk);
        sck = 1'b1;
        stream.push_back('{int'(b), cyc});
        repeat (hi) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 31; k >= 0; k--) send_bit(w[k]);
    endtask

    task automatic send_run(input bit b, input int n);
        repeat (n) send_bit(b);
    endtask

    task automatic idle_gap(input int n);
        repeat (n) @(negedge clk);
        if (n >= IDLE_TIMEOUT) stream.push_back('{2, cyc});
    endtask

    task automatic drain();
        repeat (SYNC_STAGES + 6) @(negedge clk);
    endtask

    function automatic logic [31:0] pw(input int i);
        return {8'hE1 + 8'(i), 8'(i), 8'(16 * i), 8'hFF - 8'(i)};
    endfunction

    // Word-level reading of the protocol over the recorded bit stream.
    task automatic run_model();
        int            i = 0;
        int            zeros = 0;
        int            pix = 0;
        int            nb;
        bit            hunting = 1'b1;
        logic [31:0]   w;
        logic [23:0]   shadow[LED_CNT];
        logic [FW-1:0] fr;
        exp_fv_cyc.delete();
        exp_fv_dat.delete();
        exp_se_cyc.delete();
        for (int k = 0; k < LED_CNT; k++) shadow[k] = '0;
        while (i < stream.size()) begin
            if (hunting) begin
                if (stream[i].kind == 0) zeros++;
                else if (stream[i].kind == 1) zeros = 0;
                i++;
                if (zeros == 32) begin
                    hunting = 1'b0;
                    pix = 0;
                end
            end else begin
                nb = 0;
                w  = '0;
                while (nb < 32 && i < stream.size() && stream[i].kind != 2) begin
                    w = {w[30:0], (stream[i].kind == 1) ? 1'b1 : 1'b0};
                    nb++;
                    i++;
                end
                if (nb < 32) begin
                    hunting = 1'b1;
                    zeros = 0;
                    if (i < stream.size()) i++;
                end else if (w[31:29] == 3'b111) begin
                    shadow[pix] = {w[15:8], w[7:0], w[23:16]};
                    if (pix == LED_CNT - 1) begin
                        for (int k = 0; k < LED_CNT; k++) fr[(LED_CNT-1-k)*24 +: 24] = shadow[k];
                        exp_fv_cyc.push_back(stream[i-1].cyc + SYNC_STAGES + 2);
                        exp_fv_dat.push_back(fr);
                        hunting = 1'b1;
                        zeros = 0;
                    end else begin
                        pix++;
                    end
                end else if (w == 32'h0) begin
                    pix = 0;
                end else begin
                    exp_se_cyc.push_back(stream[i-1].cyc + SYNC_STAGES + 1);
                    hunting = 1'b1;
                    zeros = 0;
                end
            end
        end
    endtask

    task automatic cmp_model(input string name);
        logic [FW-1:0] last = '0;
        run_model();
        chk_i({name, "_fv_count"}, fv_cyc.size(), exp_fv_cyc.size());
        for (int k = 0; k < fv_cyc.size() && k < exp_fv_cyc.size(); k++) begin
            chk_i({name, "_fv_cycle"}, fv_cyc[k], exp_fv_cyc[k]);
            chk({name, "_fv_data"}, fv_dat[k], exp_fv_dat[k]);
        end
        chk_i({name, "_se_count"}, se_cyc.size(), exp_se_cyc.size());
        for (int k = 0; k < se_cyc.size() && k < exp_se_cyc.size(); k++)
            chk_i({name, "_se_cycle"}, se_cyc[k], exp_se_cyc[k]);
        if (exp_fv_dat.size() > 0) last = exp_fv_dat[$];
        chk({name, "_hold"}, frame_data, last);
    endtask

    task automatic rand_frame();
        int n      = int'($urandom_range(LED_CNT + 2, 1));
        int bad_at = ($urandom_range(4, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
        send_run(1'b0, int'($urandom_range(40, 32)));
        for (int p = 0; p < n; p++) begin
            if (p == bad_at)
                send_word(($urandom_range(1, 0) == 0) ? 32'h0
                          : {3'($urandom_range(6, 0)), 29'($urandom)});
            else
                send_word({3'b111, 5'($urandom), 24'($urandom)});
        end
        send_run(1'b1, int'($urandom_range(8, 1)));
    endtask

    initial begin
        vec_t        tbl[8];
        int          last_rise;
        logic [31:0] partial;

        tbl[0] = '{32'hE10000FF, 1, 0, 24'h00FF00};
        tbl[1] = '{32'hFF123456, 1, 0, 24'h345612};
        tbl[2] = '{32'hE0ABCDEF, 1, 0, 24'hCDEFAB};
        tbl[3] = '{32'h6A112233, 0, 1, 24'h000000};
        tbl[4] = '{32'h00000000, 0, 0, 24'h000000};
        tbl[5] = '{32'hC0000000, 0, 1, 24'h000000};
        tbl[6] = '{32'h00000001, 0, 1, 24'h000000};
        tbl[7] = '{32'hEFFFFFFF, 1, 0, 24'hFFFFFF};

        do_reset();
        chk("reset_frame_data", frame_data, '0);
        chk_i("reset_frame_valid", int'(frame_valid), 0);
        chk_i("reset_sync_err", int'(sync_err), 0);

        // Pixel-0 word variants followed by LED_CNT-1 fixed filler pixels.
        lo_t = 3;
        hi_t = 3;
        for (int k = 0; k < 8; k++) begin
            do_reset();
            send_run(1'b0, 32);
            send_word(tbl[k].w);
            for (int j = 1; j < LED_CNT; j++) send_word({8'hE5, 8'(j), 8'(16 + j), 8'(32 + j)});
            send_run(1'b1, 8);
            drain();
            chk_i($sformatf("tbl%0d_fv_count", k), fv_cyc.size(), tbl[k].exp_fv);
            chk_i($sformatf("tbl%0d_se_count", k), se_cyc.size(), tbl[k].exp_se);
            chk($sformatf("tbl%0d_slot0", k), FW'(frame_data[FW-1 -: 24]), FW'(tbl[k].exp_slot0));
        end

        // Full frame at sck period 8 with commit latency check.
        lo_t = 4;
        hi_t = 4;
        do_reset();
        send_run(1'b0, 32);
        for (int p = 0; p < LED_CNT; p++) send_word(pw(p));
        last_rise = stream[$].cyc;
        send_run(1'b1, 32);
        drain();
        chk_i("full_fv_count", fv_cyc.size(), 1);
        if (fv_cyc.size() > 0) chk_i("full_fv_latency", fv_cyc[0] - last_rise, SYNC_STAGES + 2);
        chk("full_slot0", FW'(frame_data[167:144]), FW'(24'h00FF00));
        chk("full_slot6", FW'(frame_data[23:0]), FW'(24'h60F906));
        cmp_model("full");

        // Bad header, then a valid frame.
        do_reset();
        send_run(1'b0, 32);
        send_word(32'h6A112233);
        drain();
        chk_i("bad_se_count", se_cyc.size(), 1);
        chk("bad_frame_unchanged", frame_data, '0);
        send_run(1'b0, 32);
        for (int p = 0; p < LED_CNT; p++) send_word(pw(p));
        send_run(1'b1, 8);
        drain();
        chk_i("bad_then_good_fv", fv_cyc.size(), 1);
        cmp_model("bad_hdr");

        // Repeated start frame.
        do_reset();
        send_run(1'b0, 64);
        for (int p = 0; p < LED_CNT; p++) send_word(pw(p));
        drain();
        chk_i("rep_fv_count", fv_cyc.size(), 1);
        chk_i("rep_se_count", se_cyc.size(), 0);
        cmp_model("rep_start");

        // Idle abort after 3 stale pixels, then a fresh frame.
        do_reset();
        send_run(1'b0, 32);
        for (int p = 0; p < 3; p++) send_word(32'hEAAAAAAA);
        idle_gap(IDLE_TIMEOUT + 10);
        send_run(1'b0, 32);
        for (int p = 0; p < LED_CNT; p++) send_word(pw(p));
        send_run(1'b1, 32);
        drain();
        chk_i("idle_fv_count", fv_cyc.size(), 1);
        chk_i("idle_se_count", se_cyc.size(), 0);
        chk("idle_slot0", FW'(frame_data[FW-1 -: 24]), FW'(24'h00FF00));
        cmp_model("idle");

        // Extra pixels beyond the strip length.
        do_reset();
        send_run(1'b0, 32);
        for (int p = 0; p < LED_CNT + 2; p++) send_word(pw(p));
        send_run(1'b1, 8);
        drain();
        chk_i("extra_fv_count", fv_cyc.size(), 1);
        chk_i("extra_se_count", se_cyc.size(), 0);
        chk("extra_slot6", FW'(frame_data[23:0]), FW'(24'h60F906));
        cmp_model("extra");

        // Reset mid-word while the clock is stopped.
        do_reset();
        send_run(1'b0, 32);
        for (int p = 0; p < LED_CNT; p++) send_word(pw(p));
        send_run(1'b1, 8);
        drain();
        cmp_model("pre_rst");
        send_run(1'b0, 32);
        for (int p = 0; p < 3; p++) send_word(pw(p));
        partial = pw(3);
        for (int k = 31; k >= 22; k--) send_bit(partial[k]);
        chk_i("rst_pre_nonzero", int'(frame_data != '0), 1);
        clk_en = 1'b0;
        #20;
        reset = 1'b1;
        sck   = 1'b0;
        sda   = 1'b0;
        #20;
        chk("rst_stopped_frame_data", frame_data, '0);
        chk_i("rst_stopped_frame_valid", int'(frame_valid), 0);
        chk_i("rst_stopped_sync_err", int'(sync_err), 0);
        #10 reset = 1'b0;
        clear_q();
        #10 clk_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int p = 0; p < LED_CNT; p++) send_word(pw(p) ^ 32'h005A5A5A);
        send_run(1'b1, 8);
        drain();
        chk_i("rst_hunt_no_commit", fv_cyc.size(), 0);
        send_run(1'b0, 32);
        for (int p = 0; p < LED_CNT; p++) send_word(pw(p) ^ 32'h00A5A5A5);
        send_run(1'b1, 8);
        drain();
        cmp_model("post_rst");

        // Randomized streams with sck high/low times of 3..4 clk.
        rnd_t = 1'b1;
        for (int s = 0; s < 2; s++) begin
            do_reset();
            repeat (6) rand_frame();
            drain();
            repeat (50) @(negedge clk);
            cmp_model($sformatf("rand%0d", s));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
